// File: rtl/core.sv
// Core-wide decode types: ALU operation encoding and the decoded instruction record.
package core;

  typedef enum logic [4:0] {
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    BEQ, BNE, BLT, BGE, BLTU, BGEU, PASS_B, LINK,
    MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
  } ALU_OP_t;

  // Kept free of riscv types so the two packages have no compile-order dependency.
  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    ALU_OP_t     alu_op;
    logic        is_load;
    logic        is_store;
    logic [1:0]  mem_size;
    logic        mem_sign;
    logic        rd_we;
    logic        illegal;
  } decoded_t;

  function automatic ALU_OP_t arith_op(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  arith_op = alt ? SUB : ADD;
      3'b001:  arith_op = SLL;
      3'b010:  arith_op = SLT;
      3'b011:  arith_op = SLTU;
      3'b100:  arith_op = XOR;
      3'b101:  arith_op = alt ? SRA : SRL;
      3'b110:  arith_op = OR;
      default: arith_op = AND;
    endcase
  endfunction

endpackage

// File: rtl/riscv.sv
// RV32I encoding definitions: opcodes, instruction formats, register index and memory access types.
package riscv;

  typedef logic [4:0] reg_t;
  typedef logic [6:0] opcode_t;

  localparam opcode_t LUI   = 7'b0110111;
  localparam opcode_t AUIPC = 7'b0010111;
  localparam opcode_t JAL   = 7'b1101111;
  localparam opcode_t JALR  = 7'b1100111;
  localparam opcode_t B_OP  = 7'b1100011;
  localparam opcode_t L_OP  = 7'b0000011;
  localparam opcode_t S_OP  = 7'b0100011;
  localparam opcode_t I_OP  = 7'b0010011;
  localparam opcode_t RR_OP = 7'b0110011;

  typedef enum logic [1:0] {BYTE = 2'b00, HWORD = 2'b01, WORD = 2'b10} mem_size_t;
  typedef enum logic {SIGNED = 1'b0, UNSIGNED = 1'b1} mem_sign_t;

  typedef struct packed {
    logic [6:0] funct7;
    reg_t       rs2;
    reg_t       rs1;
    logic [2:0] funct3;
    reg_t       rd;
    opcode_t    opcode;
  } r_type_t;

  typedef struct packed {
    logic [11:0] imm;
    reg_t        rs1;
    logic [2:0]  funct3;
    reg_t        rd;
    opcode_t     opcode;
  } i_type_t;

  typedef struct packed {
    logic [6:0] imm_hi;
    reg_t       rs2;
    reg_t       rs1;
    logic [2:0] funct3;
    logic [4:0] imm_lo;
    opcode_t    opcode;
  } s_type_t;

  typedef struct packed {
    logic       imm12;
    logic [5:0] imm10_5;
    reg_t       rs2;
    reg_t       rs1;
    logic [2:0] funct3;
    logic [3:0] imm4_1;
    logic       imm11;
    opcode_t    opcode;
  } b_type_t;

  typedef struct packed {
    logic [19:0] imm;
    reg_t        rd;
    opcode_t     opcode;
  } u_type_t;

  typedef struct packed {
    logic       imm20;
    logic [9:0] imm10_1;
    logic       imm11;
    logic [7:0] imm19_12;
    reg_t       rd;
    opcode_t    opcode;
  } j_type_t;

  typedef union packed {
    r_type_t r;
    i_type_t i;
    s_type_t s;
    b_type_t b;
    u_type_t u;
    j_type_t j;
  } instruction_t;

endpackage

// File: rtl/decode_logic.sv
// Combinational RV32I decoder: raw instruction word -> decoded_t.
// M-extension register ops decode only when DECODE_RVM_EN is defined.
module decode_logic
  import riscv::*;
  import core::*;
(
  input  logic [31:0] instr_i,
  output decoded_t    dec_o
);

  instruction_t ins;
  logic [31:0]  imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [2:0]   funct3;
  logic [6:0]   funct7;
  logic         rd_nz;
  logic         illegal;
  decoded_t     dec;

  assign ins    = instr_i;
  assign funct3 = ins.r.funct3;
  assign funct7 = ins.r.funct7;
  assign rd_nz  = (ins.r.rd != 5'd0);

  assign imm_i = {{20{ins.i.imm[11]}}, ins.i.imm};
  assign imm_s = {{20{ins.s.imm_hi[6]}}, ins.s.imm_hi, ins.s.imm_lo};
  assign imm_b = {{19{ins.b.imm12}}, ins.b.imm12, ins.b.imm11, ins.b.imm10_5, ins.b.imm4_1, 1'b0};
  assign imm_u = {ins.u.imm, 12'b0};
  assign imm_j = {{11{ins.j.imm20}}, ins.j.imm20, ins.j.imm19_12, ins.j.imm11, ins.j.imm10_1, 1'b0};

  always_comb begin
    dec     = '0;
    illegal = 1'b0;
    dec.rs1 = ins.r.rs1;
    dec.rs2 = ins.r.rs2;
    dec.rd  = ins.r.rd;
    case (ins.r.opcode)
      I_OP: begin
        dec.imm    = imm_i;
        dec.rd_we  = rd_nz;
        dec.alu_op = arith_op(funct3, (funct3 == 3'b101) && funct7[5]);
        if (funct3 == 3'b001)
          illegal = (funct7 != 7'b0);
        else if (funct3 == 3'b101)
          illegal = (funct7 != 7'b0) && (funct7 != 7'b0100000);
      end
      RR_OP: begin
        dec.rd_we = rd_nz;
        if (funct7 == 7'b0)
          dec.alu_op = arith_op(funct3, 1'b0);
        else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))
          dec.alu_op = arith_op(funct3, 1'b1);
`ifdef DECODE_RVM_EN
        else if (funct7 == 7'b0000001) begin
          case (funct3)
            3'b000:  dec.alu_op = MUL;
            3'b001:  dec.alu_op = MULH;
            3'b010:  dec.alu_op = MULHSU;
            3'b011:  dec.alu_op = MULHU;
            3'b100:  dec.alu_op = DIV;
            3'b101:  dec.alu_op = DIVU;
            3'b110:  dec.alu_op = REM;
            default: dec.alu_op = REMU;
          endcase
        end
`endif
        else
          illegal = 1'b1;
      end
      L_OP: begin
        dec.is_load  = 1'b1;
        dec.imm      = imm_i;
        dec.rd_we    = rd_nz;
        dec.mem_size = funct3[1:0];
        dec.mem_sign = funct3[2];
        illegal      = (funct3[1:0] == 2'b11);
      end
      S_OP: begin
        dec.is_store = 1'b1;
        dec.imm      = imm_s;
        dec.rd       = 5'd0;
        dec.mem_size = funct3[1:0];
        illegal      = (funct3[1:0] == 2'b11) || funct3[2];
      end
      B_OP: begin
        dec.imm = imm_b;
        case (funct3)
          3'b000:  dec.alu_op = BEQ;
          3'b001:  dec.alu_op = BNE;
          3'b100:  dec.alu_op = BLT;
          3'b101:  dec.alu_op = BGE;
          3'b110:  dec.alu_op = BLTU;
          3'b111:  dec.alu_op = BGEU;
          default: illegal    = 1'b1;
        endcase
      end
      LUI: begin
        dec.imm    = imm_u;
        dec.alu_op = PASS_B;
        dec.rd_we  = rd_nz;
      end
      AUIPC: begin
        dec.imm    = imm_u;
        dec.alu_op = ADD;
        dec.rd_we  = rd_nz;
      end
      JAL: begin
        dec.imm    = imm_j;
        dec.alu_op = LINK;
        dec.rd_we  = rd_nz;
      end
      JALR: begin
        dec.imm    = imm_i;
        dec.alu_op = LINK;
        dec.rd_we  = rd_nz;
        illegal    = (funct3 != 3'b000);
      end
      default: illegal = 1'b1;
    endcase
    // Illegal words carry no side effects downstream: every other field is zeroed.
    if (illegal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  assign dec_o = dec;

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: decoder feeding a DEPTH-entry queue with valid/ready on both sides.
// Optional M-extension decode via DECODE_RVM_EN (see decode_logic).
module decode_stage
  import riscv::*;
  import core::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] pc_o,
  output reg_t            rs1_o,
  output reg_t            rs2_o,
  output reg_t            rd_o,
  output logic [XLEN-1:0] imm_o,
  output ALU_OP_t         alu_op_o,
  output logic            is_load_o,
  output logic            is_store_o,
  output mem_size_t       mem_size_o,
  output logic            mem_unsigned_o,
  output logic            rd_we_o,
  output logic            illegal_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  decoded_t         dec;
  decoded_t         head;
  decoded_t         slot_reg    [DEPTH];
  logic [XLEN-1:0]  pc_slot_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             push, pop;

  decode_logic u_decode (
    .instr_i (instr_i),
    .dec_o   (dec)
  );

  assign in_ready_o  = rst && (count_reg != CNT_W'(DEPTH));
  assign out_valid_o = (count_reg != '0);
  assign push        = in_valid_i && in_ready_o && !flush_i;
  assign pop         = out_valid_o && out_ready_i && !flush_i;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush_i) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Slots reset to zero so every output reads 0 while the stage is held in reset.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          slot_reg[gi]    <= '0;
          pc_slot_reg[gi] <= '0;
        end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
          slot_reg[gi]    <= dec;
          pc_slot_reg[gi] <= pc_i;
        end
      end
    end
  endgenerate

  assign head           = slot_reg[rd_ptr_reg];
  assign pc_o           = pc_slot_reg[rd_ptr_reg];
  assign rs1_o          = head.rs1;
  assign rs2_o          = head.rs2;
  assign rd_o           = head.rd;
  assign imm_o          = XLEN'($signed(head.imm));
  assign alu_op_o       = head.alu_op;
  assign is_load_o      = head.is_load;
  assign is_store_o     = head.is_store;
  assign mem_size_o     = mem_size_t'(head.mem_size);
  assign mem_unsigned_o = head.mem_sign;
  assign rd_we_o        = head.rd_we;
  assign illegal_o      = head.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized bench for decode_stage: queue-based reference model plus directed literal cases.
module tb_decode_stage;
  import riscv::*;
  import core::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic [31:0]     instr_i;
  logic [XLEN-1:0] pc_i, pc_o, imm_o;
  reg_t            rs1_o, rs2_o, rd_o;
  ALU_OP_t         alu_op_o;
  logic            is_load_o, is_store_o, mem_unsigned_o, rd_we_o, illegal_o;
  mem_size_t       mem_size_o;

  decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .instr_i(instr_i), .pc_i(pc_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .pc_o(pc_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .imm_o(imm_o), .alu_op_o(alu_op_o),
    .is_load_o(is_load_o), .is_store_o(is_store_o), .mem_size_o(mem_size_o),
    .mem_unsigned_o(mem_unsigned_o), .rd_we_o(rd_we_o), .illegal_o(illegal_o)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, rs1, rs2, rd, imm, alu, ld, st, size, uns, we, ill;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam ALU_OP_t ARITH  [8] = '{ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND};
  localparam ALU_OP_t BRANCH [8] = '{BEQ, BNE, ADD, ADD, BLT, BGE, BLTU, BGEU};
`ifdef DECODE_RVM_EN
  localparam ALU_OP_t MDU    [8] = '{MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU};
`endif

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Expected decode straight from the ISA field layout, using plain shifts and masks.
  function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc);
    exp_t        e;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [31:0] sx;
    logic        ill, writes;
    ALU_OP_t     alu;
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    sx = $signed(w) >>> 20;
    e.pc = pc; e.rs1 = 32'(w[19:15]); e.rs2 = 32'(w[24:20]); e.rd = 32'(w[11:7]);
    e.imm = 0; e.ld = 0; e.st = 0; e.size = 0; e.uns = 0;
    alu = ADD; ill = 0; writes = 0;
    case (op)
      7'h13: begin
        e.imm = sx; writes = 1;
        alu = (f3 == 3'd5 && f7 == 7'h20) ? SRA : ARITH[f3];
        ill = (f3 == 3'd1 && f7 != 0) || (f3 == 3'd5 && f7 != 0 && f7 != 7'h20);
      end
      7'h33: begin
        writes = 1;
        if (f7 == 0) alu = ARITH[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) alu = SUB;
        else if (f7 == 7'h20 && f3 == 3'd5) alu = SRA;
`ifdef DECODE_RVM_EN
        else if (f7 == 7'h01) alu = MDU[f3];
`endif
        else ill = 1;
      end
      7'h03: begin
        e.ld = 1; writes = 1; e.imm = sx; e.size = 32'(f3[1:0]); e.uns = 32'(f3[2]);
        ill = (f3[1:0] == 2'd3);
      end
      7'h23: begin
        e.st = 1; e.rd = 0; e.imm = {sx[31:5], w[11:7]}; e.size = 32'(f3[1:0]);
        ill = (f3[1:0] == 2'd3) || f3[2];
      end
      7'h63: begin
        e.imm = (w[31] ? 32'hFFFFF000 : 32'h0) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5)
              | (32'(w[11:8]) << 1);
        alu = BRANCH[f3];
        ill = (f3 == 3'd2) || (f3 == 3'd3);
      end
      7'h37: begin e.imm = w & 32'hFFFFF000; alu = PASS_B; writes = 1; end
      7'h17: begin e.imm = w & 32'hFFFFF000; alu = ADD; writes = 1; end
      7'h6F: begin
        e.imm = (w[31] ? 32'hFFF00000 : 32'h0) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11)
              | (32'(w[30:21]) << 1);
        alu = LINK; writes = 1;
      end
      7'h67: begin e.imm = sx; alu = LINK; writes = 1; ill = (f3 != 0); end
      default: ill = 1;
    endcase
    e.alu = 32'(alu);
    e.we  = 32'(writes && e.rd != 0);
    e.ill = 32'(ill);
    if (ill) begin
      e.rs1 = 0; e.rs2 = 0; e.rd = 0; e.imm = 0; e.alu = 32'(ADD);
      e.ld = 0; e.st = 0; e.size = 0; e.uns = 0; e.we = 0;
    end
    return e;
  endfunction

  function automatic void check_dut();
    chk("in_ready", 32'(in_ready_o), 32'(q.size() < DEPTH));
    chk("out_valid", 32'(out_valid_o), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("pc", pc_o, q[0].pc);
      chk("rs1", 32'(rs1_o), q[0].rs1);
      chk("rs2", 32'(rs2_o), q[0].rs2);
      chk("rd", 32'(rd_o), q[0].rd);
      chk("imm", imm_o, q[0].imm);
      chk("alu_op", 32'(alu_op_o), q[0].alu);
      chk("is_load", 32'(is_load_o), q[0].ld);
      chk("is_store", 32'(is_store_o), q[0].st);
      chk("mem_size", 32'(mem_size_o), q[0].size);
      chk("mem_unsigned", 32'(mem_unsigned_o), q[0].uns);
      chk("rd_we", 32'(rd_we_o), q[0].we);
      chk("illegal", 32'(illegal_o), q[0].ill);
    end
  endfunction

  // Called at a falling edge: drive one cycle, advance the model, then compare at the next falling edge.
  task automatic step(input logic v, input logic [31:0] w, input logic [31:0] pc,
                      input logic rdy, input logic fl);
    logic do_push, do_pop;
    in_valid_i = v; instr_i = w; pc_i = pc; out_ready_i = rdy; flush_i = fl;
    do_push = v && (q.size() < DEPTH);
    do_pop  = rdy && (q.size() != 0);
    if (fl) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(model(w, pc));
    end
    @(negedge clk);
    $display("cycle t=%0t v=%0b instr=%h pc=%h rdy=%0b flush=%0b -> out_valid=%0b pc_o=%h in_ready=%0b",
             $time, v, w, pc, rdy, fl, out_valid_o, pc_o, in_ready_o);
    check_dut();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int unsigned k;
    logic [6:0]  ops [9];
    ops = '{7'h13, 7'h33, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
    w = $urandom;
    k = $urandom_range(0, 10);
    if (k < 9) w[6:0] = ops[k];
    else if (k == 9) begin
      w[6:0] = 7'h33;
      case ($urandom_range(0, 2))
        0:       w[31:25] = 7'h00;
        1:       w[31:25] = 7'h20;
        default: w[31:25] = 7'h01;
      endcase
    end
    if ((w[6:0] == 7'h13) && ($urandom_range(0, 1) == 1))
      w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    return w;
  endfunction

  task automatic push_one(input logic [31:0] w);
    step(1'b1, w, 32'h1000, 1'b0, 1'b0);
  endtask

  task automatic drain();
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; flush_i = 0; in_valid_i = 0; out_ready_i = 0; instr_i = 0; pc_i = 0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready_o), 32'd0);
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_imm", imm_o, 32'd0);
    rst = 1'b1;
    #1 check_dut();
    @(negedge clk);

    // addi x0,x0,0
    push_one(32'h00000013);
    chk("addi_valid", 32'(out_valid_o), 32'd1);
    chk("addi_alu", 32'(alu_op_o), 32'(ADD));
    chk("addi_we", 32'(rd_we_o), 32'd0);
    chk("addi_imm", imm_o, 32'd0);
    chk("addi_ill", 32'(illegal_o), 32'd0);
    drain();
    // sh x5,2(x1)
    push_one(32'h00509123);
    chk("sh_store", 32'(is_store_o), 32'd1);
    chk("sh_size", 32'(mem_size_o), 32'(HWORD));
    chk("sh_rs1", 32'(rs1_o), 32'd1);
    chk("sh_rs2", 32'(rs2_o), 32'd5);
    chk("sh_imm", imm_o, 32'd2);
    chk("sh_rd", 32'(rd_o), 32'd0);
    chk("sh_we", 32'(rd_we_o), 32'd0);
    drain();
    // lbu x8,15(x1)
    push_one(32'h00F0C403);
    chk("lbu_load", 32'(is_load_o), 32'd1);
    chk("lbu_size", 32'(mem_size_o), 32'(BYTE));
    chk("lbu_uns", 32'(mem_unsigned_o), 32'd1);
    chk("lbu_rd", 32'(rd_o), 32'd8);
    chk("lbu_imm", imm_o, 32'd15);
    drain();
    // lw x9,-1(x1)
    push_one(32'hFFF0A483);
    chk("lw_imm", imm_o, 32'hFFFFFFFF);
    drain();
    push_one(32'h0000007F);
    chk("bad_opcode_ill", 32'(illegal_o), 32'd1);
    drain();
    push_one(32'h00003003);
    chk("load_f3_011_ill", 32'(illegal_o), 32'd1);
    drain();
    // mul x3,x1,x2
    push_one(32'h022081B3);
`ifdef DECODE_RVM_EN
    chk("mul_alu", 32'(alu_op_o), 32'(MUL));
    chk("mul_we", 32'(rd_we_o), 32'd1);
`else
    chk("mul_ill", 32'(illegal_o), 32'd1);
`endif
    drain();

    // Backpressure: third push refused until the queue drains.
    step(1'b1, 32'h00100093, 32'h200, 1'b0, 1'b0);
    step(1'b1, 32'h00200113, 32'h204, 1'b0, 1'b0);
    chk("bp_ready_full", 32'(in_ready_o), 32'd0);
    step(1'b1, 32'h00300193, 32'h208, 1'b0, 1'b0);
    chk("bp_head_a", pc_o, 32'h200);
    step(1'b1, 32'h00300193, 32'h208, 1'b1, 1'b0);
    chk("bp_head_b", pc_o, 32'h204);
    step(1'b1, 32'h00300193, 32'h208, 1'b1, 1'b0);
    chk("bp_head_c", pc_o, 32'h208);
    drain();
    chk("bp_empty", 32'(out_valid_o), 32'd0);

    // Full queue, pop, simultaneous push+pop, then flush.
    step(1'b1, 32'h00100093, 32'h300, 1'b0, 1'b0);
    step(1'b1, 32'h00200113, 32'h304, 1'b0, 1'b0);
    step(1'b1, 32'h00300193, 32'h308, 1'b1, 1'b0);
    step(1'b1, 32'h00400213, 32'h30C, 1'b1, 1'b0);
    chk("pp_head", pc_o, 32'h30C);
    step(1'b1, 32'h00500293, 32'h310, 1'b1, 1'b1);
    chk("flush_valid", 32'(out_valid_o), 32'd0);
    chk("flush_ready", 32'(in_ready_o), 32'd1);

    // Reset asserted mid-stream clears outputs without waiting for a clock edge.
    step(1'b1, 32'hFFF0A483, 32'h400, 1'b0, 1'b0);
    step(1'b1, 32'h00509123, 32'h404, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("mrst_valid", 32'(out_valid_o), 32'd0);
    chk("mrst_ready", 32'(in_ready_o), 32'd0);
    chk("mrst_pc", pc_o, 32'd0);
    chk("mrst_imm", imm_o, 32'd0);
    chk("mrst_rs", {rs1_o, rs2_o, rd_o}, 32'd0);
    chk("mrst_flags", {is_load_o, is_store_o, mem_unsigned_o, rd_we_o, illegal_o}, 32'd0);
    chk("mrst_alu", 32'(alu_op_o), 32'(ADD));
    q.delete();
    in_valid_i = 0; out_ready_i = 0; flush_i = 0;
    @(negedge clk);
    rst = 1'b1;
    #1 check_dut();

    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom_range(0, 2) != 0,
           $urandom_range(0, 40) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
